// File: rtl/shared_reg_arb_pkg.sv
// Shared types and constants for the shared register arbiter.
// State enum, grant ids and init counter width.
package shared_reg_arb_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam logic GNT_0 = 1'b0;
  localparam logic GNT_1 = 1'b1;

  localparam int CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick; grant is one-hot or zero.
// Ports: valid[1:0], last_grant, enable in; grant[1:0] out.
module rr_arb2
  import shared_reg_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // On a tie the requester not served last wins.
        2'b11:   grant = (last_grant == GNT_1) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Owns one sync-clearable register; init sequence, then round-robin
// writes from two requesters with clear priority. Ports: C, R, clr_req,
// req0/1 valid/data/ready, Q, busy, upd, last_grant.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               INIT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic             clr_req,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             upd,
  output logic             last_grant
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(INIT_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             run;

  assign run = (state == ST_RUN);

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     (run && !clr_req),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign busy       = !run;

  always_ff @(posedge C or negedge R) begin
    if (!R) state <= ST_INIT;
    else    state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_INIT: if (cnt == CNT_LAST) state_nx = ST_RUN;
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge C or negedge R) begin
    if (!R)       cnt <= '0;
    else if (!run) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      Q          <= RST_VAL;
      upd        <= 1'b0;
      last_grant <= GNT_1;
    end else begin
      upd <= 1'b0;
      if (!run) begin
        Q <= RST_VAL;
      end else if (clr_req) begin
        // Clear pulses upd even if Q already equals RST_VAL.
        Q   <= RST_VAL;
        upd <= 1'b1;
      end else if (grant[0]) begin
        Q          <= req0_data;
        last_grant <= GNT_0;
        upd        <= 1'b1;
      end else if (grant[1]) begin
        Q          <= req1_data;
        last_grant <= GNT_1;
        upd        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: directed phases then
// randomized traffic against a cycle-level reference model.
module tb_shared_reg_arbiter;

  localparam int         W   = 8;
  localparam int         IC  = 4;
  localparam logic [7:0] RV  = 8'h5A;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       clr_req = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = '0;
  logic       req1_ready;
  logic [7:0] Q;
  logic       busy;
  logic       upd;
  logic       last_grant;

  shared_reg_arbiter #(
    .WIDTH(W), .INIT_CYCLES(IC), .RST_VAL(RV)
  ) dut (
    .C(C), .R(R), .clr_req(clr_req),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .Q(Q), .busy(busy), .upd(upd), .last_grant(last_grant)
  );

  always #5 C = ~C;

  typedef struct {
    logic       r0;
    logic       r1;
    logic       busy;
    logic [7:0] q;
    logic       upd;
    logic       lg;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: edges left in init, register, flags.
  int         init_left;
  logic [7:0] mq;
  logic       mupd;
  logic       mlg;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, got, want, $time);
    end
  endtask

  task automatic model_reset();
    init_left = IC;
    mq        = RV;
    mupd      = 1'b0;
    mlg       = 1'b1;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic clr, input logic v0,
                     input logic [7:0] d0, input logic v1,
                     input logic [7:0] d1, output int win);
    exp_t e;
    clr_req    = clr;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
    win    = -1;
    e.busy = (init_left > 0);
    if (init_left > 0) begin
      init_left--;
      mq   = RV;
      mupd = 1'b0;
    end else if (clr) begin
      mq   = RV;
      mupd = 1'b1;
    end else begin
      if (v0 && v1) win = mlg ? 0 : 1;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
      mupd = (win >= 0);
      if (win == 0) begin mq = d0; mlg = 1'b0; end
      if (win == 1) begin mq = d1; mlg = 1'b1; end
    end
    e.r0  = (win == 0);
    e.r1  = (win == 1);
    e.q   = mq;
    e.upd = mupd;
    e.lg  = mlg;
    sb.push_back(e);
    @(negedge C);
  endtask

  // Monitor: readies/busy before the edge, registers after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge C);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("req0_ready", req0_ready, e.r0);
        chk("req1_ready", req1_ready, e.r1);
        chk("busy", busy, e.busy);
        @(posedge C);
        #1;
        chk("Q", Q, e.q);
        chk("upd", upd, e.upd);
        chk("last_grant", last_grant, e.lg);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic async_reset_check();
    #3;
    R = 1'b0;
    #1;
    chk("rst_Q", Q, RV);
    chk("rst_r0", req0_ready, 1'b0);
    chk("rst_r1", req1_ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_upd", upd, 1'b0);
    chk("rst_lg", last_grant, 1'b1);
    clr_req    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_reset();
    @(negedge C);
    @(negedge C);
    R = 1'b1;
  endtask

  initial begin
    int         win;
    int         n;
    logic       p0, p1;
    logic [7:0] pd0, pd1;
    model_reset();
    repeat (2) @(negedge C);
    #1;
    chk("por_Q", Q, RV);
    chk("por_busy", busy, 1'b1);
    chk("por_lg", last_grant, 1'b1);
    @(negedge C);
    R = 1'b1;

    // Init with req0 waiting from the start.
    n = 0;
    do begin
      cyc(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, win);
      n++;
    end while (win != 0 && n < 20);
    chk("init_accept_cycle", n, IC + 1);

    // Both valid: strict alternation.
    repeat (8) cyc(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, win);

    // Clear beats both, then the tie goes to the other one.
    cyc(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, win);
    cyc(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, win);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, win);

    // Single requester.
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, win);

    // Idle hold.
    repeat (10) cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, win);

    chk("pre_rst_Q", Q, 8'h3C);
    async_reset_check();

    // Random traffic; requesters hold until accepted.
    p0 = 1'b0; p1 = 1'b0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(1, 0) == 1) begin
        p0 = 1'b1; pd0 = 8'($urandom);
      end
      if (!p1 && $urandom_range(1, 0) == 1) begin
        p1 = 1'b1; pd1 = 8'($urandom);
      end
      cyc($urandom_range(9, 0) == 0, p0, pd0, p1, pd1, win);
      if (win == 0) p0 = 1'b0;
      if (win == 1) p1 = 1'b0;
      if (i == 200) begin
        async_reset_check();
        p0 = 1'b0;
        p1 = 1'b0;
      end
    end

    repeat (3) @(negedge C);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
